// File: rtl/cpu_pkg.sv
// Types and ALU control encodings shared by decode and the Execute-stage
// divide/modulo sequencer.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_MUL = 3'b010;
    localparam logic [2:0] ALU_DIV = 3'b011;
    localparam logic [2:0] ALU_MOD = 3'b100;
    localparam logic [2:0] ALU_MOV = 3'b101;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration: shift {rem,quo} left by one and
// subtract the divisor when the shifted remainder is large enough.
module div_step
    import cpu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0] rem_shift;
    logic [WIDTH:0] trial;

    // Extra top bit keeps the borrow of the trial subtraction as its sign.
    assign rem_shift = {rem, quo[WIDTH-1]};
    assign trial     = rem_shift - {1'b0, divisor};

    assign rem_next = trial[WIDTH] ? rem_shift[WIDTH-1:0] : trial[WIDTH-1:0];
    assign quo_next = {quo[WIDTH-2:0], ~trial[WIDTH]};

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle unsigned DIV/MOD unit beside the Execute-stage ALU; holds the
// pipeline through stall until the result is ready.
module div_sequencer
    import cpu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op_mod,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             div_zero
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    div_state_t       state_q, state_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             op_mod_q, op_mod_d;
    logic             div_zero_q, div_zero_d;
    logic             accept;
    logic [WIDTH-1:0] step_rem, step_quo;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .divisor  (divisor_q),
        .rem_next (step_rem),
        .quo_next (step_quo)
    );

    assign accept   = start && !flush && (state_q == IDLE || state_q == DONE);
    // Low in DONE so Execute advances; a back-to-back op stalls from RUN on.
    assign stall    = (accept && state_q == IDLE) || (state_q == RUN);
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign result   = result_q;
    assign div_zero = div_zero_q;

    always_comb begin
        state_d    = state_q;
        quo_d      = quo_q;
        rem_d      = rem_q;
        divisor_d  = divisor_q;
        result_d   = result_q;
        cnt_d      = cnt_q;
        op_mod_d   = op_mod_q;
        div_zero_d = div_zero_q;

        if (flush) begin
            state_d = IDLE;
        end else if (accept) begin
            divisor_d = divisor;
            op_mod_d  = op_mod;
            cnt_d     = CNT_W'(WIDTH);
            if (divisor == '0) begin
                quo_d      = '1;
                rem_d      = dividend;
                result_d   = op_mod ? dividend : '1;
                div_zero_d = 1'b1;
                state_d    = DONE;
            end else begin
                quo_d   = dividend;
                rem_d   = '0;
                state_d = RUN;
            end
        end else begin
            case (state_q)
                RUN: begin
                    quo_d = step_quo;
                    rem_d = step_rem;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        result_d   = op_mod_q ? step_rem : step_quo;
                        div_zero_d = 1'b0;
                        state_d    = DONE;
                    end
                end
                DONE:    state_d = IDLE;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            quo_q      <= '0;
            rem_q      <= '0;
            divisor_q  <= '0;
            result_q   <= '0;
            cnt_q      <= '0;
            op_mod_q   <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            quo_q      <= quo_d;
            rem_q      <= rem_d;
            divisor_q  <= divisor_d;
            result_q   <= result_d;
            cnt_q      <= cnt_d;
            op_mod_q   <= op_mod_d;
            div_zero_q <= div_zero_d;
        end
    end

endmodule
